aesl_deadlock_detect_unit: RTL and testbench

Per-process deadlock detector for the co-simulation dataflow monitor; one instance sits beside each dataflow process in the kernel wrapper. It filters the process's blocking conditions into a detection bit and then acts as one hop of the token ring that traces dependence cycles. The report unit, `AESL_deadlock_report_unit`, sees the OR of every instance's `dl_out` as its `dl_in_vec`, and each instance consumes that unit's `origin` and `token_clear`.

---
 rtl/aesl_dl_pkg.sv | 14 +
 rtl/aesl_dl_lowest_onehot.sv | 12 +
 rtl/aesl_deadlock_detect_unit.sv | 101 ++++++++++
 tb/tb_aesl_deadlock_detect_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_dl_pkg.sv
// rtl/aesl_dl_pkg.sv - shared state encoding and counter width for the deadlock detector
package aesl_dl_pkg;

    localparam int BLK_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILTER = 3'd1,
        ST_DL     = 3'd2,
        ST_TOKEN  = 3'd3,
        ST_PASSED = 3'd4
    } dl_state_t;

endpackage

// File: rtl/aesl_dl_lowest_onehot.sv
// rtl/aesl_dl_lowest_onehot.sv - combinational lowest-set-bit one-hot pick
module aesl_dl_lowest_onehot #(
    parameter int W = 2
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] onehot
);

    // Two's-complement trick isolates the least significant set bit.
    assign onehot = vec & (~vec + W'(1));

endmodule

// File: rtl/aesl_deadlock_detect_unit.sv
// rtl/aesl_deadlock_detect_unit.sv - per-process blocking filter and token-ring hop
module aesl_deadlock_detect_unit
    import aesl_dl_pkg::*;
#(
    parameter int PROC_NUM   = 4,
    parameter int PROC_ID    = 0,
    parameter int DEP_NUM    = 2,
    parameter int BLK_THRESH = 4
) (
    input  logic                dl_clock,
    input  logic                dl_reset,
    input  logic [DEP_NUM-1:0]  blk_vec,
    input  logic [PROC_NUM-1:0] origin,
    input  logic                token_clear,
    input  logic [DEP_NUM-1:0]  token_in,
    output logic [DEP_NUM-1:0]  token_out,
    output logic [PROC_NUM-1:0] dl_out
);

    localparam logic [PROC_NUM-1:0]  DL_MASK  = PROC_NUM'(1) << PROC_ID;
    localparam logic [BLK_CNT_W-1:0] CNT_LAST = BLK_CNT_W'(BLK_THRESH - 1);

    dl_state_t            state;
    dl_state_t            state_next;
    logic [BLK_CNT_W-1:0] cnt;
    logic [BLK_CNT_W-1:0] cnt_next;
    logic                 blocked;
    logic                 take_token;
    logic [DEP_NUM-1:0]   pick;
    logic                 unused_origin;

    assign blocked       = |blk_vec;
    assign take_token    = origin[PROC_ID] | (|token_in);
    // Only our own origin bit matters; the rest belong to other instances.
    assign unused_origin = ^origin;

    aesl_dl_lowest_onehot #(.W(DEP_NUM)) u_pick (
        .vec    (blk_vec),
        .onehot (pick)
    );

    // Next-state and counter update; token_clear outranks the unblock exit,
    // which outranks token acceptance.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (blocked) begin
                    if (BLK_THRESH <= 1) begin
                        state_next = ST_DL;
                    end else begin
                        state_next = ST_FILTER;
                        cnt_next   = BLK_CNT_W'(1);
                    end
                end
            end
            ST_FILTER: begin
                if (!blocked) begin
                    state_next = ST_IDLE;
                end else begin
                    if (cnt >= CNT_LAST) state_next = ST_DL;
                    if (cnt != '1) cnt_next = cnt + BLK_CNT_W'(1);
                end
            end
            ST_DL: begin
                if (token_clear)     state_next = ST_DL;
                else if (!blocked)   state_next = ST_IDLE;
                else if (take_token) state_next = ST_TOKEN;
            end
            ST_TOKEN: begin
                if (token_clear)   state_next = ST_DL;
                else if (!blocked) state_next = ST_IDLE;
                else               state_next = ST_PASSED;
            end
            ST_PASSED: begin
                if (token_clear)   state_next = ST_DL;
                else if (!blocked) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next == ST_IDLE) cnt_next = '0;
    end

    // State, counter and outputs registered together so outputs track the new state.
    always_ff @(posedge dl_clock) begin
        if (!dl_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dl_out    <= '0;
            token_out <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dl_out    <= (state_next == ST_DL || state_next == ST_TOKEN) ? DL_MASK : '0;
            token_out <= (state_next == ST_TOKEN) ? pick : '0;
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_detect_unit.sv
// tb/tb_aesl_deadlock_detect_unit.sv - self-checking bench for the deadlock detector
module tb_aesl_deadlock_detect_unit;

    typedef struct packed {
        logic       rst_n;
        logic [1:0] blk;
        logic [1:0] blkb;
        logic [3:0] org;
        logic       clr;
        logic [1:0] tin;
        logic [3:0] dla;
        logic [1:0] toka;
        logic [3:0] dlb;
        logic [1:0] tokb;
    } step_t;

    typedef struct packed {
        logic [3:0] dla;
        logic [1:0] toka;
        logic [3:0] dlb;
        logic [1:0] tokb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] blk;
    logic [1:0] blk_b;
    logic [3:0] origin;
    logic       tclr;
    logic [1:0] tin;
    logic       ring;
    logic [1:0] a_tin, b_tin, a_tok, b_tok;
    logic [3:0] a_dl, b_dl;
    int         checks   = 0;
    int         failures = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    assign a_tin = tin | (ring ? {1'b0, b_tok[0]} : 2'b00);
    assign b_tin = ring ? {1'b0, a_tok[0]} : 2'b00;

    aesl_deadlock_detect_unit #(.PROC_NUM(4), .PROC_ID(1), .DEP_NUM(2), .BLK_THRESH(4)) dut (
        .dl_clock    (clk),
        .dl_reset    (rstn),
        .blk_vec     (blk),
        .origin      (origin),
        .token_clear (tclr),
        .token_in    (a_tin),
        .token_out   (a_tok),
        .dl_out      (a_dl)
    );

    aesl_deadlock_detect_unit #(.PROC_NUM(4), .PROC_ID(2), .DEP_NUM(2), .BLK_THRESH(4)) dut_b (
        .dl_clock    (clk),
        .dl_reset    (rstn),
        .blk_vec     (blk_b),
        .origin      (origin),
        .token_clear (tclr),
        .token_in    (b_tin),
        .token_out   (b_tok),
        .dl_out      (b_dl)
    );

    function automatic step_t s(input logic r, input logic [1:0] b, input logic [1:0] bb,
                                input logic [3:0] o, input logic c, input logic [1:0] t,
                                input logic [3:0] da, input logic [1:0] ta,
                                input logic [3:0] db, input logic [1:0] tb2);
        return {r, b, bb, o, c, t, da, ta, db, tb2};
    endfunction

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 0, 0, 2, 1, 0, 0));
        st.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL reset step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
    endtask

    task automatic test_filter();
        step_t st[$];
        exp_t  e;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL filter step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
    endtask

    task automatic test_origin();
        step_t st[$];
        exp_t  e;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 0, 0, 2, 1, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL origin step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
    endtask

    task automatic test_token_in();
        step_t st[$];
        exp_t  e;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 2, 0, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 2, 2, 1, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 3, 0, 0, 0, 2, 0, 0, 0, 0));
        st.push_back(s(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL token_in step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
    endtask

    task automatic test_clear();
        step_t st[$];
        exp_t  e;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 1, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 2, 0, 0, 2, 1, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 1, 0, 2, 0, 0, 0));
        st.push_back(s(1, 1, 0, 0, 0, 2, 2, 1, 0, 0));
        st.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL clear step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
    endtask

    task automatic test_ring();
        step_t st[$];
        exp_t  e;
        ring = 1'b1;
        st.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(s(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 1, 0, 0, 0, 2, 0, 4, 0));
        st.push_back(s(1, 1, 1, 2, 0, 0, 2, 1, 4, 0));
        st.push_back(s(1, 1, 1, 0, 0, 0, 0, 0, 4, 1));
        st.push_back(s(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 1, 0, 1, 0, 2, 0, 4, 0));
        st.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            rstn = st[i].rst_n; blk = st[i].blk; blk_b = st[i].blkb;
            origin = st[i].org; tclr = st[i].clr; tin = st[i].tin;
            sb.push_back({st[i].dla, st[i].toka, st[i].dlb, st[i].tokb});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({a_dl, a_tok, b_dl, b_tok} !== e) begin
                failures++;
                $display("FAIL ring step %0d: got dl_a=%b tok_a=%b dl_b=%b tok_b=%b want %b %b %b %b",
                         i, a_dl, a_tok, b_dl, b_tok, e.dla, e.toka, e.dlb, e.tokb);
            end
        end
        ring = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; blk = '0; blk_b = '0; origin = '0; tclr = 1'b0; tin = '0; ring = 1'b0;
        test_reset();
        test_filter();
        test_origin();
        test_token_in();
        test_clear();
        test_ring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
